// File: rtl/weight_buffer_param_pkg.sv
// Shared definitions for the weight buffer: buffer state encoding and default geometry.
package weight_buffer_param_pkg;

    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_LANES      = 16;
    localparam int DEF_BANKS      = 2;
    localparam int DEF_DEPTH      = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        READY = 1'b1
    } buf_state_t;

endpackage

// File: rtl/weight_bank_ram.sv
// One weight bank: simple dual-port RAM, one write port and one registered read port.
module weight_bank_ram #(
    parameter  int WIDTH = 288,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Contents are deliberately never reset; read returns old data on a same-address write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_buffer_param.sv
// Banked weight buffer: word-granular loading with fill tracking, and a 2-cycle read
// that fetches consecutive (wrapping) words, one per bank, in a single request.
module weight_buffer_param
    import weight_buffer_param_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int LANES      = DEF_LANES,
    parameter  int BANKS      = DEF_BANKS,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BANK_WIDTH = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_valid,
    input  logic [BANK_WIDTH-1:0]               load_bank,
    input  logic [ADDR_WIDTH-1:0]               load_addr,
    input  logic [DATA_WIDTH*LANES-1:0]         load_data,
    input  logic                                rd_req,
    input  logic [ADDR_WIDTH-1:0]               rd_index,
    output logic                                rd_ready,
    output logic                                out_valid,
    output logic [BANKS*LANES*DATA_WIDTH-1:0]   q,
    output logic                                loaded,
    input  logic                                clear
);

    localparam int WORD_W = DATA_WIDTH * LANES;
    localparam int TOTAL  = BANKS * DEPTH;
    localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CNT_W  = $clog2(TOTAL + 1);

    buf_state_t              r_state;
    buf_state_t              w_nextState;
    logic [TOTAL-1:0]        r_written;
    logic [CNT_W-1:0]        r_fillCount;
    logic [ADDR_WIDTH-1:0]   r_rdAddr [BANKS];
    logic [WORD_W-1:0]       w_ramQ   [BANKS];
    logic                    r_vAddr;
    logic                    r_vRam;
    logic                    r_outValid;
    logic [BANKS*WORD_W-1:0] r_q;
    logic                    w_loadOk;
    logic                    w_accept;
    logic [IDX_W-1:0]        w_loadIdx;

    assign w_loadOk  = load_valid && (32'(load_bank) < BANKS);
    assign w_loadIdx = IDX_W'(32'(load_bank) * 32'(DEPTH) + 32'(load_addr));
    // Loads have priority over reads; a refused requester simply retries.
    assign w_accept  = rd_req && !load_valid && (r_state == READY);

    assign rd_ready  = w_accept;
    assign loaded    = (r_state == READY);
    assign out_valid = r_outValid;
    assign q         = r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (!clear && (r_fillCount == CNT_W'(TOTAL))) w_nextState = READY;
            READY:   if (clear) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    // Only the first write to a word counts; clear beats a same-cycle load for tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_written   <= '0;
            r_fillCount <= '0;
        end else if (clear) begin
            r_written   <= '0;
            r_fillCount <= '0;
        end else if (w_loadOk && !r_written[w_loadIdx]) begin
            r_written[w_loadIdx] <= 1'b1;
            r_fillCount          <= r_fillCount + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                r_rdAddr[b] <= '0;
            end
            r_vAddr    <= 1'b0;
            r_vRam     <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int b = 0; b < BANKS; b++) begin
                    r_rdAddr[b] <= ADDR_WIDTH'((32'(rd_index) + 32'(b)) % 32'(DEPTH));
                end
            end
            r_vAddr    <= w_accept && !clear;
            r_vRam     <= r_vAddr && !clear;
            r_outValid <= r_vRam && !clear;
        end
    end

    // q only moves when a read completes, so it holds the last result otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (r_vRam && !clear) begin
            for (int b = 0; b < BANKS; b++) begin
                r_q[b*WORD_W +: WORD_W] <= w_ramQ[b];
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        weight_bank_ram #(
            .WIDTH (WORD_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_loadOk && (load_bank == BANK_WIDTH'(b))),
            .i_waddr (load_addr),
            .i_wdata (load_data),
            .i_raddr (r_rdAddr[b]),
            .o_rdata (w_ramQ[b])
        );
    end

endmodule

// File: tb/tb_weight_buffer_param.sv
// Directed, table-driven bench for weight_buffer_param at its default geometry
// (18-bit weights, 16 lanes, 2 banks, 64 words).
module tb_weight_buffer_param;

    localparam int DW = 18;
    localparam int LN = 16;
    localparam int BK = 2;
    localparam int DP = 64;
    localparam int AW = 6;
    localparam int WW = DW * LN;
    localparam int QW = BK * WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_bank;
    logic [AW-1:0] load_addr;
    logic [WW-1:0] load_data;
    logic          rd_req;
    logic [AW-1:0] rd_index;
    logic          rd_ready;
    logic          out_valid;
    logic [QW-1:0] q;
    logic          loaded;
    logic          clear;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [AW-1:0] idx;
        int            exp0;
        int            exp1;
    } readVec_t;

    readVec_t vecs [5];

    weight_buffer_param dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_bank  (load_bank),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .rd_req     (rd_req),
        .rd_index   (rd_index),
        .rd_ready   (rd_ready),
        .out_valid  (out_valid),
        .q          (q),
        .loaded     (loaded),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] laneWord(input int v);
        logic [WW-1:0] w;
        for (int l = 0; l < LN; l++) begin
            w[l*DW +: DW] = DW'(v);
        end
        return w;
    endfunction

    function automatic logic [QW-1:0] expQ(input int e0, input int e1);
        return {laneWord(e1), laneWord(e0)};
    endfunction

    task automatic checkOutput(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic applyStimulus(input logic lv, input logic lb, input logic [AW-1:0] la,
                                 input logic [WW-1:0] ld, input logic rq,
                                 input logic [AW-1:0] ri, input logic clr);
        load_valid = lv;
        load_bank  = lb;
        load_addr  = la;
        load_data  = ld;
        rd_req     = rq;
        rd_index   = ri;
        clear      = clr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes bank b word a with lane value a*2+b; loaded must rise only after the last new word.
    task automatic loadAll();
        for (int b = 0; b < BK; b++) begin
            for (int a = 0; a < DP; a++) begin
                applyStimulus(1'b1, 1'(b), AW'(a), laneWord(a * 2 + b), 1'b0, '0, 1'b0);
                if (b == BK - 1 && a == DP - 1) checkBit("loadedBeforeLastWord", loaded, 1'b0);
                tick();
            end
        end
        idle();
        tick();
        checkBit("loadedAfterFill", loaded, 1'b1);
    endtask

    task automatic doRead(input string name, input logic [AW-1:0] idx, input int e0, input int e1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, idx, 1'b0);
        #1;
        checkBit({name, "_rdReady"}, rd_ready, 1'b1);
        tick();
        idle();
        checkBit({name, "_ovN"}, out_valid, 1'b0);
        tick();
        checkBit({name, "_ovN1"}, out_valid, 1'b0);
        tick();
        checkBit({name, "_ovN2"}, out_valid, 1'b1);
        checkOutput({name, "_q"}, q, expQ(e0, e1));
        tick();
        checkBit({name, "_ovDrop"}, out_valid, 1'b0);
        checkOutput({name, "_qHold"}, q, expQ(e0, e1));
    endtask

    initial begin
        vecs[0] = '{idx: 6'd5,  exp0: 10,  exp1: 13};
        vecs[1] = '{idx: 6'd63, exp0: 126, exp1: 1};
        vecs[2] = '{idx: 6'd0,  exp0: 0,   exp1: 3};
        vecs[3] = '{idx: 6'd62, exp0: 124, exp1: 127};
        vecs[4] = '{idx: 6'd31, exp0: 62,  exp1: 65};

        // Reset state, with a read request pending against an empty buffer.
        reset = 1'b1;
        idle();
        rd_req = 1'b1;
        #12;
        checkBit("resetOutValid", out_valid, 1'b0);
        checkBit("resetLoaded", loaded, 1'b0);
        checkBit("resetRdReady", rd_ready, 1'b0);
        checkOutput("resetQ", q, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkBit($sformatf("emptyRdReady%0d", i), rd_ready, 1'b0);
            checkBit($sformatf("emptyOutValid%0d", i), out_valid, 1'b0);
            checkBit($sformatf("emptyLoaded%0d", i), loaded, 1'b0);
            tick();
        end

        idle();
        loadAll();

        for (int i = 0; i < 5; i++) begin
            doRead($sformatf("read%0d", i), vecs[i].idx, vecs[i].exp0, vecs[i].exp1);
        end

        // Back-to-back reads produce one result per cycle.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 6'd20, 1'b0);
        #1;
        checkBit("b2bReady0", rd_ready, 1'b1);
        tick();
        rd_index = 6'd21;
        #1;
        checkBit("b2bReady1", rd_ready, 1'b1);
        tick();
        idle();
        tick();
        checkBit("b2bOv0", out_valid, 1'b1);
        checkOutput("b2bQ0", q, expQ(40, 43));
        tick();
        checkBit("b2bOv1", out_valid, 1'b1);
        checkOutput("b2bQ1", q, expQ(42, 45));
        tick();
        checkBit("b2bOvDrop", out_valid, 1'b0);

        // Load and read collide: load wins, the retried read sees the new data.
        applyStimulus(1'b1, 1'b0, 6'd10, laneWord(174762), 1'b1, 6'd10, 1'b0);
        #1;
        checkBit("collideRdReady", rd_ready, 1'b0);
        tick();
        load_valid = 1'b0;
        #1;
        checkBit("retryRdReady", rd_ready, 1'b1);
        tick();
        idle();
        checkBit("retryOvN", out_valid, 1'b0);
        tick();
        checkBit("retryOvN1", out_valid, 1'b0);
        tick();
        checkBit("retryOvN2", out_valid, 1'b1);
        checkOutput("retryQ", q, expQ(174762, 23));

        // Rewrites of a single word never fill the buffer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset2Q", q, '0);
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1'b1, 1'b0, 6'd0, laneWord(0), 1'b0, '0, 1'b0);
            tick();
        end
        idle();
        tick();
        checkBit("rewriteLoaded", loaded, 1'b0);

        // Clear while a read is in flight.
        loadAll();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 6'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        tick();
        idle();
        checkBit("clearLoaded", loaded, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkBit($sformatf("clearOv%0d", i), out_valid, 1'b0);
            tick();
        end
        checkOutput("clearQ", q, '0);

        // Reset between accept and result discards the read.
        loadAll();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 6'd7, 1'b0);
        tick();
        idle();
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkBit($sformatf("midResetOv%0d", i), out_valid, 1'b0);
            tick();
        end
        checkOutput("midResetQ", q, '0);
        checkBit("midResetLoaded", loaded, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/weight_buffer_param.md
WEIGHT_BUFFER_PARAM -- requirements
Module: weight_buffer_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, meaning bits per weight.
REQ-002 SHALL have parameter LANES, default 16, meaning weights per bank word.
REQ-003 SHALL have parameter BANKS, default 2, meaning parallel RAM banks.
REQ-004 SHALL have parameter DEPTH, default 64, meaning words per bank; ADDR_WIDTH = clog2(DEPTH).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port load_valid, input, 1, meaning a load beat is presented.
REQ-008 SHALL have port load_bank, input, clog2(BANKS) (min 1), meaning target bank.
REQ-009 SHALL have port load_addr, input, ADDR_WIDTH, meaning target word.
REQ-010 SHALL have port load_data, input, DATA_WIDTH*LANES, meaning packed word, lane 0 in LSBs.
REQ-011 SHALL have port rd_req, input, 1, meaning read request.
REQ-012 SHALL have port rd_index, input, ADDR_WIDTH, meaning read base index.
REQ-013 SHALL have port rd_ready, output, 1, meaning rd_req accepted this cycle.
REQ-014 SHALL have port out_valid, output, 1, meaning q carries a read result.
REQ-015 SHALL have port q, output, BANKS*LANES*DATA_WIDTH, meaning bank b lane l at bits [(b*LANES+l)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port loaded, output, 1, meaning every word of every bank written since reset or clear.
REQ-017 SHALL have port clear, input, 1, meaning synchronous reset of fill tracking.

Function
REQ-018 Bank b SHALL read address (rd_index + b) mod DEPTH; wrap-around at DEPTH-1 required.
REQ-019 Read latency SHALL be exactly 2 cycles: accept at edge N (address register), RAM output register at N+1, out_valid high and q valid after edge N+2.
REQ-020 out_valid SHALL be a 2-stage shift of accepted reads; back-to-back accepted reads give one result per cycle.
REQ-021 q SHALL hold its last value when no read completes; out_valid low then.
REQ-022 Load beat SHALL write load_data to load_bank[load_addr] on the edge where load_valid is high; one-cycle write, always accepted.
REQ-023 Simultaneous load_valid and rd_req: load wins, rd_ready=0, read not accepted; requester retries.
REQ-024 rd_ready SHALL equal rd_req AND NOT load_valid AND state==READY (combinational).
REQ-025 State machine: EMPTY (reads refused), READY (reads accepted). EMPTY->READY when fill counter reaches BANKS*DEPTH; READY->EMPTY on clear.
REQ-026 Fill tracking: per-word written bitmap (BANKS*DEPTH bits); counter increments only on first write to a word; rewrites do not count.
REQ-027 loaded SHALL equal (state==READY).
REQ-028 clear SHALL zero bitmap and counter, force EMPTY, flush the out_valid pipeline; RAM contents untouched; clear with load_valid same cycle: clear wins, load still writes RAM but is not counted.
REQ-029 load_bank >= BANKS SHALL be ignored (no write, no count).

Reset
REQ-030 Reset SHALL asynchronously force state EMPTY, counter 0, bitmap 0, out_valid 0, address registers 0, q 0.
REQ-031 RAM contents SHALL not be reset; reset mid-read discards in-flight results (no out_valid after deassert).

Structure
REQ-032 Shared package SHALL hold the state enum (EMPTY, READY) and default DATA_WIDTH/LANES/BANKS/DEPTH constants.
REQ-033 Storage SHALL be BANKS instances of sub-module weight_bank_ram (1 write port, 1 registered read port, DATA_WIDTH*LANES wide, DEPTH deep).

Verification
REQ-034 Reset, rd_req=1 idx 0 -> rd_ready=0, out_valid stays 0, loaded=0.
REQ-035 Load all 128 words (bank b word a = pattern a*2+b per lane), then rd_index=5 -> 2 cycles later q bank0=word5, bank1=word6, out_valid one cycle.
REQ-036 rd_index=63 -> bank0 word63, bank1 word0 (wrap).
REQ-037 Loaded buffer, rd_req and load_valid same cycle -> rd_ready=0, no result; next cycle read returns newly loaded data.
REQ-038 Rewrite one word 128 times after reset -> loaded stays 0; then clear during READY -> loaded=0 next cycle, pending out_valid suppressed.
REQ-039 Reset asserted between accept and result -> out_valid never rises; q=0.
